// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: FSM states, opcode classes
// and the opcode values that select each non-ALU class.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU   = 3'd0,
    CL_LOAD  = 3'd1,
    CL_STORE = 3'd2,
    CL_BEQ   = 3'd3,
    CL_BNE   = 3'd4,
    CL_JUMP  = 3'd5
  } op_class_t;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_SW  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1011;
  localparam logic [3:0] OP_BNE = 4'b1100;
  localparam logic [3:0] OP_J   = 4'b1101;

endpackage

// File: rtl/seq_op_class.sv
// Combinational opcode classifier; anything not explicitly listed is an ALU op.
module seq_op_class
  import seq_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_t  op_class
);

  // Opcode to class lookup
  always_comb begin
    op_class = CL_ALU;
    case (opcode)
      OP_LW:   op_class = CL_LOAD;
      OP_SW:   op_class = CL_STORE;
      OP_BEQ:  op_class = CL_BEQ;
      OP_BNE:  op_class = CL_BNE;
      OP_J:    op_class = CL_JUMP;
      default: op_class = CL_ALU;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer FSM with a bounded memory wait.
// Optional SEQ_PERF_CNT_EN adds retired/stall performance counters.
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [3:0]  opcode,
  output logic        instr_ready,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        jump_sel,
  output logic        alu_en,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_write,
  output logic        instr_done,
  output logic        err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0] retired_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // wait_cnt holds the number of MEM cycles already spent, so the last allowed one is MAX-1
  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state;
  state_t     next_state;
  logic [3:0] opcode_q;
  logic [7:0] wait_cnt;
  op_class_t  op_class;

  seq_op_class u_op_class (
    .opcode   (opcode_q),
    .op_class (op_class)
  );

  // State, latched opcode and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      opcode_q <= 4'b0000;
      wait_cnt <= 8'd0;
    end else begin
      state <= next_state;
      if (pc_inc) begin
        opcode_q <= opcode;
      end
      if ((state == ST_MEM) && (next_state == ST_MEM)) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  // Next-state and strobe decode; reset forces every strobe low
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    jump_sel    = 1'b0;
    alu_en      = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    err         = 1'b0;
    if (rst) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) begin
            pc_inc     = 1'b1;
            next_state = ST_DECODE;
          end else begin
            next_state = ST_IDLE;
          end
        end
        ST_DECODE: begin
          if (op_class == CL_JUMP) begin
            pc_load    = 1'b1;
            jump_sel   = 1'b1;
            instr_done = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_en = 1'b1;
          case (op_class)
            CL_ALU:   next_state = ST_WB;
            CL_LOAD:  next_state = ST_MEM;
            CL_STORE: next_state = ST_MEM;
            CL_BEQ: begin
              pc_load    = zero;
              instr_done = 1'b1;
              next_state = ST_IDLE;
            end
            CL_BNE: begin
              pc_load    = ~zero;
              instr_done = 1'b1;
              next_state = ST_IDLE;
            end
            default:  next_state = ST_IDLE;
          endcase
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (op_class == CL_STORE);
          // A late mem_ready still beats the timeout on the final cycle
          if (mem_ready) begin
            if (op_class == CL_STORE) begin
              instr_done = 1'b1;
              next_state = ST_IDLE;
            end else begin
              next_state = ST_WB;
            end
          end else if (wait_cnt >= WAIT_LAST) begin
            err        = 1'b1;
            next_state = ST_IDLE;
          end else begin
            next_state = ST_MEM;
          end
        end
        ST_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Retired-instruction and memory-stall counters, free-running with wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= 32'd0;
      stall_cnt   <= 32'd0;
    end else begin
      if (instr_done) begin
        retired_cnt <= retired_cnt + 32'd1;
      end
      if ((state == ST_MEM) && !mem_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15: maximum cycles spent in MEM waiting for mem_ready before timeout (range 1..255).
REQ-002 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  fetched instruction available.
- opcode  input  4  opcode of the fetched instruction, sampled on accept.
- instr_ready  output  1  sequencer can accept an instruction.
- zero  input  1  ALU zero flag, sampled in EXEC.
- mem_ready  input  1  data memory completes the access.
- pc_inc  output  1  PC+1 pulse on accept.
- pc_load  output  1  load branch/jump target into PC.
- jump_sel  output  1  PC target is the jump target; 0 means branch target.
- alu_en  output  1  ALU operand/result registers capture.
- mem_req  output  1  data memory request.
- mem_we  output  1  request is a write.
- reg_write  output  1  register file write strobe.
- instr_done  output  1  instruction retired.
- err  output  1  memory timeout pulse.

Function
REQ-003 SHALL implement states IDLE, DECODE, EXEC, MEM, WB; encoding is free.
REQ-004 SHALL classify opcodes: 0000=LOAD, 0001=STORE, 1011=BEQ, 1100=BNE, 1101=JUMP, all others=ALU (including 1010, 1110, 1111).
REQ-005 In IDLE it SHALL drive instr_ready=1; on instr_valid&instr_ready it SHALL latch opcode, pulse pc_inc and go to DECODE.
REQ-006 In DECODE, JUMP SHALL drive pc_load=1, jump_sel=1 and instr_done=1, then go to IDLE; every other class SHALL go to EXEC.
REQ-007 In EXEC it SHALL drive alu_en=1.
- ALU: go to WB.
- LOAD/STORE: go to MEM.
- BEQ/BNE: taken = (BEQ&zero)|(BNE&~zero); pc_load=taken, jump_sel=0, instr_done=1; go to IDLE.
REQ-008 In MEM it SHALL hold mem_req=1 and mem_we=(class==STORE) every cycle until mem_ready is sampled high.
- On mem_ready, STORE: instr_done=1, go to IDLE.
- On mem_ready, LOAD: go to WB.
REQ-009 SHALL count MEM cycles. If the count reaches MEM_WAIT_MAX with mem_ready low, it SHALL pulse err for one cycle, drive no instr_done and go to IDLE. A mem_ready arriving on that same cycle SHALL take priority: no err, normal completion.
REQ-010 In WB it SHALL drive reg_write=1 and instr_done=1, then go to IDLE.
REQ-011 All strobes SHALL be combinational decodes of the state register and latched opcode only, so each strobe is high exactly one cycle per instruction except mem_req/mem_we. instr_valid SHALL be ignored outside IDLE.
REQ-012 Latency from accept edge to instr_done (zero-wait memory): JUMP 1, branch 2, ALU 3, STORE 3, LOAD 4 cycles; each memory wait cycle adds 1.

Reset
REQ-013 While rst is high, state SHALL be IDLE, the wait counter 0 and the latched opcode 0000. Every output SHALL be 0, including instr_ready.
REQ-014 A reset asserted mid-instruction SHALL abandon it with no instr_done, reg_write or pc_load. instr_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-015 With macro SEQ_PERF_CNT_EN defined, the block SHALL add these outputs:
- retired_cnt  output  32  increments on every instr_done, wraps at 2^32, cleared by rst.
- stall_cnt  output  32  increments on every MEM cycle with mem_ready low, wraps at 2^32, cleared by rst.
REQ-016 Without SEQ_PERF_CNT_EN these ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-017 Package seq_pkg SHALL hold the state enum, the opcode-class enum and the opcode localparams (OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J).
REQ-018 Combinational sub-module seq_op_class SHALL map opcode[3:0] to the class enum. The FSM, wait counter and performance counters SHALL stay in instr_sequencer.

Verification
REQ-019 Reset then opcode 0010 valid -> pc_inc at accept, alu_en +2, reg_write and instr_done +3, instr_ready back the following cycle.
REQ-020 LW with mem_ready delayed 3 cycles -> mem_req high 4 cycles, mem_we=0, reg_write and instr_done in the next cycle.
REQ-021 BEQ with zero=1, then BNE with zero=1 -> first retires with pc_load=1, jump_sel=0; second retires with pc_load=0.
REQ-022 SW with mem_ready never asserted, MEM_WAIT_MAX=15 -> mem_req=1, mem_we=1 for 15 cycles, one err pulse, no instr_done, returns to IDLE.
REQ-023 rst pulsed while in MEM during an LW -> no reg_write or instr_done. Opcode 1101 then accepted -> pc_load=1, jump_sel=1, instr_done 1 cycle later.
REQ-024 With SEQ_PERF_CNT_EN: 10 mixed instructions including 5 memory wait cycles -> retired_cnt=10, stall_cnt=5; rst clears both to 0.
